// File: rtl/gan_pixel_pkg.sv
// Shared types and constants for the pixel compare stages.
// Holds the checker FSM encoding and the CRC-16/CCITT step.
package gan_pixel_pkg;

    localparam int PIXEL_W_DEFAULT     = 16;
    localparam int PIXEL_COUNT_DEFAULT = 784;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SRC = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } chk_state_e;

    // MSB-first over one default-width pixel
    function automatic logic [15:0] crc16_step(
        input logic [15:0]                crc,
        input logic [PIXEL_W_DEFAULT-1:0] data
    );
        logic [15:0] c;
        c = crc;
        for (int b = PIXEL_W_DEFAULT - 1; b >= 0; b--) begin
            if (c[15] ^ data[b]) begin
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/pixel_abs_diff.sv
// Combinational |a - b| for signed pixels, one bit wider than the
// operands so the full range (e.g. 0x8000 vs 0x7FFF) is exact.
module pixel_abs_diff #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   abs_o
);

    logic [W:0] diff;

    assign diff  = {a_i[W-1], a_i} - {b_i[W-1], b_i};
    assign abs_o = diff[W] ? (~diff + 1'b1) : diff;

endmodule

// File: rtl/pixel_stream_checker.sv
// Compares a valid/ready pixel stream against a static expected frame.
// Optional CRC of accepted pixels: define PIXEL_CHECKER_CRC_EN.
module pixel_stream_checker
    import gan_pixel_pkg::*;
#(
    parameter int                 PIXEL_COUNT = PIXEL_COUNT_DEFAULT,
    parameter int                 PIXEL_W     = PIXEL_W_DEFAULT,
    parameter logic [PIXEL_W-1:0] TOLERANCE   = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [PIXEL_W*PIXEL_COUNT-1:0]     expected_flat,
    input  logic                               has_expected,
    input  logic                               data_valid,
    input  logic                               pix_valid,
    input  logic [PIXEL_W-1:0]                 pix_data,
    output logic                               pix_ready,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic                               skipped,
    output logic [$clog2(PIXEL_COUNT+1)-1:0]   mismatch_count,
    output logic [PIXEL_W:0]                   max_abs_err,
    output logic [$clog2(PIXEL_COUNT)-1:0]     first_mismatch_idx,
    output logic                               first_mismatch_valid,
    output logic [15:0]                        crc_out
);

    localparam int CNT_W = $clog2(PIXEL_COUNT + 1);
    localparam int IDX_W = $clog2(PIXEL_COUNT);

    chk_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  mm_q, mm_d;
    logic [PIXEL_W:0]  max_q, max_d;
    logic [IDX_W-1:0]  fidx_q, fidx_d;
    logic              fvalid_q, fvalid_d;
    logic              pass_q, pass_d;
    logic              skip_q, skip_d;
    logic              hexp_q, hexp_d;
    logic [PIXEL_W-1:0] exp_pix;
    logic [PIXEL_W:0]  abs_err;

    assign exp_pix = expected_flat[int'(idx_q) * PIXEL_W +: PIXEL_W];

    pixel_abs_diff #(
        .W (PIXEL_W)
    ) u_abs (
        .a_i   (pix_data),
        .b_i   (exp_pix),
        .abs_o (abs_err)
    );

`ifdef PIXEL_CHECKER_CRC_EN
    logic [15:0] crc_q, crc_d;
    assign crc_out = crc_q;
`else
    assign crc_out = 16'h0000;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mm_d     = mm_q;
        max_d    = max_q;
        fidx_d   = fidx_q;
        fvalid_d = fvalid_q;
        pass_d   = pass_q;
        skip_d   = skip_q;
        hexp_d   = hexp_q;
`ifdef PIXEL_CHECKER_CRC_EN
        crc_d    = crc_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d    = '0;
                    mm_d     = '0;
                    max_d    = '0;
                    fidx_d   = '0;
                    fvalid_d = 1'b0;
                    pass_d   = 1'b0;
                    skip_d   = 1'b0;
`ifdef PIXEL_CHECKER_CRC_EN
                    crc_d    = CRC16_INIT;
`endif
                    if (data_valid) begin
                        state_d = ST_RUN;
                        skip_d  = ~has_expected;
                        hexp_d  = has_expected;
                    end else begin
                        state_d = ST_WAIT_SRC;
                    end
                end
            end
            ST_WAIT_SRC: begin
                if (data_valid) begin
                    state_d = ST_RUN;
                    skip_d  = ~has_expected;
                    hexp_d  = has_expected;
                end
            end
            ST_RUN: begin
                if (pix_valid) begin
                    idx_d = idx_q + 1'b1;
`ifdef PIXEL_CHECKER_CRC_EN
                    crc_d = crc16_step(crc_q, PIXEL_W_DEFAULT'(pix_data));
`endif
                    if (hexp_q) begin
                        if (abs_err > {1'b0, TOLERANCE}) begin
                            mm_d = mm_q + 1'b1;
                            if (!fvalid_q) begin
                                fvalid_d = 1'b1;
                                fidx_d   = idx_q;
                            end
                        end
                        if (abs_err > max_q) begin
                            max_d = abs_err;
                        end
                    end
                    // last pixel: index parks instead of wrapping
                    if (idx_q == IDX_W'(PIXEL_COUNT - 1)) begin
                        idx_d   = idx_q;
                        state_d = ST_DONE;
                        pass_d  = hexp_q && (mm_d == '0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            mm_q     <= '0;
            max_q    <= '0;
            fidx_q   <= '0;
            fvalid_q <= 1'b0;
            pass_q   <= 1'b0;
            skip_q   <= 1'b0;
            hexp_q   <= 1'b0;
`ifdef PIXEL_CHECKER_CRC_EN
            crc_q    <= 16'h0000;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mm_q     <= mm_d;
            max_q    <= max_d;
            fidx_q   <= fidx_d;
            fvalid_q <= fvalid_d;
            pass_q   <= pass_d;
            skip_q   <= skip_d;
            hexp_q   <= hexp_d;
`ifdef PIXEL_CHECKER_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign pix_ready            = (state_q == ST_RUN);
    assign busy                 = (state_q == ST_WAIT_SRC) || (state_q == ST_RUN);
    assign done                 = (state_q == ST_DONE);
    assign pass                 = pass_q;
    assign skipped              = skip_q;
    assign mismatch_count       = mm_q;
    assign max_abs_err          = max_q;
    assign first_mismatch_idx   = fidx_q;
    assign first_mismatch_valid = fvalid_q;

endmodule

// File: doc/pixel_stream_checker.md
Name: pixel_stream_checker

Overview:
- Sequential consumer of the static expected-frame bus (`expected_flat`, `has_expected`, `data_valid`).
- Accepts a generated pixel stream over a valid/ready handshake and compares each pixel against its slot in `expected_flat`.
- Accumulates mismatch statistics and raises `done` with a pass/fail verdict.
- Sits at the tail of the generator datapath, beside the frame ROM.

Parameters:
- PIXEL_COUNT, 784, pixels per frame (28*28).
- PIXEL_W, 16, bits per pixel; signed two's complement.
- TOLERANCE, 0, maximum absolute difference still counted as a match (unsigned, PIXEL_W bits).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame check.
- expected_flat  in  PIXEL_W*PIXEL_COUNT  expected frame; pixel i at bits [(i+1)*PIXEL_W-1 -: PIXEL_W].
- has_expected  in  1  expected frame present.
- data_valid  in  1  expected bus stable and usable.
- pix_valid  in  1  stream pixel valid.
- pix_data  in  PIXEL_W  stream pixel.
- pix_ready  out  1  checker accepts a pixel this cycle.
- busy  out  1  high in WAIT_SRC or RUN.
- done  out  1  level; high in DONE.
- pass  out  1  valid when done; 1 iff has_expected and mismatch_count==0.
- skipped  out  1  valid when done; 1 iff has_expected was 0 at RUN entry.
- mismatch_count  out  $clog2(PIXEL_COUNT+1)  pixels with |diff| > TOLERANCE.
- max_abs_err  out  PIXEL_W+1  largest |pix_data - expected| seen.
- first_mismatch_idx  out  $clog2(PIXEL_COUNT)  index of first mismatch.
- first_mismatch_valid  out  1  at least one mismatch recorded.
- crc_out  out  16  running CRC of accepted pixels (see Optional Feature).

Behaviour:
- Reset: state IDLE. `pix_ready`, `busy`, `done`, `pass`, `skipped`, `first_mismatch_valid` all 0. All counters, `max_abs_err`, `first_mismatch_idx` and `crc_out` are 0.
- States:
  - IDLE: on `start`, clear all statistics and the index counter. Go to RUN if `data_valid`=1, else to WAIT_SRC.
  - WAIT_SRC: `busy`=1, `pix_ready`=0. Go to RUN on the first cycle `data_valid`=1.
  - RUN entry: latch `skipped` = ~has_expected.
  - RUN: `pix_ready`=1. A transfer occurs when `pix_valid`&&`pix_ready`; there are no bubbles inserted by the checker.
    - Per transfer, compute diff = sign-extended `pix_data` minus sign-extended expected[idx], PIXEL_W+1 bits, then take abs.
    - If has_expected and abs > TOLERANCE: increment `mismatch_count`. On the first mismatch, set `first_mismatch_valid` and latch idx.
    - `max_abs_err` updates on every transfer when has_expected.
    - idx increments after each transfer. The transfer at idx==PIXEL_COUNT-1 moves to DONE on the next edge; no wrap.
  - DONE: `done`=1, `pix_ready`=0, statistics frozen. `start` clears and restarts exactly as from IDLE; `done` drops on that same edge.
- `pass` is registered on entry to DONE.
- `start` while in WAIT_SRC or RUN is ignored.
- `data_valid` falling during RUN is ignored; the latched mode holds.
- `rst` mid-frame aborts to the reset state in one cycle.
- `mismatch_count` cannot overflow: its width holds PIXEL_COUNT.
- Latency: `done` rises one cycle after the last accepted pixel.

Optional Feature:
- Macro: PIXEL_CHECKER_CRC_EN.
- Defined: `crc_out` is updated on every transfer with CRC-16/CCITT (poly 0x1021, init 0xFFFF, MSB first) over `pix_data`. The init value is loaded on `start`, and the CRC is frozen in DONE.
- Undefined: `crc_out` is tied to 16'h0000 and no CRC logic is instantiated. All other behaviour is identical.

Decomposition:
- Shared package `gan_pixel_pkg`:
  - PIXEL_W_DEFAULT, PIXEL_COUNT_DEFAULT.
  - checker state enum {IDLE, WAIT_SRC, RUN, DONE}.
  - CRC16_POLY, CRC16_INIT constants.
  - function `crc16_step(crc, data)`.
- One sub-module: `pixel_abs_diff`, a combinational signed subtract plus abs that outputs PIXEL_W+1 bits. It is reused by other compare stages.

Test Plan:
- Matching frame: expected all 16'h0100, stream identical, `pix_valid` constantly 1, `start` with `data_valid`=1 -> `done` at cycle 785 after `start`; `pass`=1, `mismatch_count`=0, `max_abs_err`=0.
- Injected errors, TOLERANCE=0: pixel 5 = exp+3, pixel 700 = exp-0x20 -> `mismatch_count`=2, `first_mismatch_idx`=5, `max_abs_err`=0x20, `pass`=0. Rerun with TOLERANCE=4 -> `mismatch_count`=1, `first_mismatch_idx`=700.
- Sign extremes: expected 16'h7FFF, pixel 16'h8000 -> abs = 17'h0FFFF, `max_abs_err`=17'h0FFFF, no truncation.
- Handshake gaps: random `pix_valid` at 30% duty -> same statistics as the contiguous case. `pix_ready` stays 0 in WAIT_SRC; hold `data_valid` low 10 cycles after `start`, then assert -> RUN entered on the next edge.
- `has_expected`=0: full frame streamed -> `done`=1, `skipped`=1, `pass`=0, `mismatch_count`=0.
- Reset at pixel 400 -> all outputs at reset values next cycle; a new `start` completes a clean frame. `start` pulsed mid-RUN is ignored. With PIXEL_CHECKER_CRC_EN defined, `crc_out` matches the reference model for the all-0x0100 frame; undefined, `crc_out`=0.
